// File: rtl/requant_pkg.sv
// rtl/requant_pkg.sv - shared definitions for the requantiser pipeline
// Purpose: rounding-mode encodings and the legal-parameter check used by
//          requant_pipe.
// Contents:
//   rq_mode_t     mode encodings (2'b11 is not named and behaves as truncate)
//   rq_params_ok  returns 1 when a width/shift combination can be built
package requant_pkg;

  typedef enum logic [1:0] {
    RQ_TRUNC = 2'b00,
    RQ_RHU   = 2'b01,
    RQ_CONV  = 2'b10
  } rq_mode_t;

  // The kept field must be at least as wide as the output word, and at least
  // one fractional bit must be discarded for rounding to mean anything.
  function automatic bit rq_params_ok(input int in_w, input int out_w,
                                      input int shift, input int cnt_w);
    return (shift >= 1) && (shift < in_w) && (out_w >= 1) &&
           (in_w - shift >= out_w) && (cnt_w >= 1);
  endfunction

endpackage

// File: rtl/requant_pipe.sv
// rtl/requant_pipe.sv - two-stage requantiser: round, shift, saturate
// Purpose: reduce a wide fixed-point sample to an OUT_W-bit word using
//          truncation, round-half-up or convergent rounding, followed by
//          saturation to the output range. Valid/ready on both sides.
// Optional feature: define SAT_COUNT_EN to add the saturation event counter
//          (sat_count / sat_clr ports); without it those ports do not exist.
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous reset, active-low
//   mode       00 trunc, 01 round-half-up, 10 convergent, 11 trunc
//   in_data    IN_W-bit input sample
//   in_valid   input sample present
//   in_ready   sample accepted this cycle when in_valid is high
//   out_data   OUT_W-bit requantised sample
//   out_sat    out_data was clamped
//   out_valid  output present
//   out_ready  downstream accepts
//   sat_count  clamp events transferred since reset/clear (SAT_COUNT_EN)
//   sat_clr    synchronous clear of sat_count, wins over increment (SAT_COUNT_EN)
module requant_pipe
  import requant_pkg::*;
#(
  parameter int IN_W   = 22,
  parameter int OUT_W  = 8,
  parameter int SHIFT  = 14,
  parameter bit SIGNED = 1'b0,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       mode,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_sat,
  output logic             out_valid,
  input  logic             out_ready
`ifdef SAT_COUNT_EN
  ,
  output logic [CNT_W-1:0] sat_count,
  input  logic             sat_clr
`endif
);

  if (!rq_params_ok(IN_W, OUT_W, SHIFT, CNT_W)) begin : g_bad_params
    $error("requant_pipe: illegal IN_W/OUT_W/SHIFT/CNT_W combination");
  end

  // Integer part after the shift, one bit wider than IN_W-SHIFT so the
  // rounding carry out of the top can never wrap.
  localparam int HI_W = IN_W - SHIFT + 1;

  localparam logic [SHIFT-1:0] HALF  = SHIFT'(64'd1 << (SHIFT - 1));
  localparam logic [OUT_W-1:0] S_MIN = OUT_W'(64'd1 << (OUT_W - 1));
  localparam logic [OUT_W-1:0] S_MAX = ~S_MIN;
  localparam logic [OUT_W-1:0] U_MAX = '1;

  logic            adv;
  logic            s1_valid;
  logic [HI_W-1:0] s1_hi;

  // ---------------------------------------------------------------- stage 1
  // Adding an increment of 0 or HALF and then discarding SHIFT bits is the
  // same as adding a single carry into the kept field, where the carry is
  // the frac MSB. Only the kept field is registered; the fraction can no
  // longer influence the result once the carry has been taken.
  logic [SHIFT-1:0] frac;
  logic             tie;
  logic             carry;
  logic             ext_msb;
  logic [HI_W-1:0]  hi_c;

  assign frac    = in_data[SHIFT-1:0];
  assign tie     = (frac == HALF);
  assign ext_msb = SIGNED ? in_data[IN_W-1] : 1'b0;

  always_comb begin
    carry = 1'b0;
    case (mode)
      RQ_RHU:  carry = frac[SHIFT-1];
      // Exact tie with an even kept LSB stays put (round half to even).
      RQ_CONV: carry = frac[SHIFT-1] && !(tie && !in_data[SHIFT]);
      default: carry = 1'b0;
    endcase
  end

  assign hi_c = {ext_msb, in_data[IN_W-1:SHIFT]} + HI_W'(carry);

  // ---------------------------------------------------------------- stage 2
  // s1_hi already holds the (arithmetically) shifted value; only the clamp
  // remains. Signed values fit when every bit from OUT_W-1 upward matches
  // the sign; unsigned values fit when every bit from OUT_W upward is zero.
  logic [OUT_W-1:0]    q_c;
  logic                sat_c;
  logic [HI_W-OUT_W:0] s_upper;

  assign s_upper = s1_hi[HI_W-1:OUT_W-1];

  always_comb begin
    q_c   = s1_hi[OUT_W-1:0];
    sat_c = 1'b0;
    if (SIGNED) begin
      if (!((s_upper == '0) || (s_upper == '1))) begin
        sat_c = 1'b1;
        q_c   = s1_hi[HI_W-1] ? S_MIN : S_MAX;
      end
    end else begin
      if (|s1_hi[HI_W-1:OUT_W]) begin
        sat_c = 1'b1;
        q_c   = U_MAX;
      end
    end
  end

  // ------------------------------------------------------------- handshake
  // The whole pipe moves together: it advances whenever the output register
  // is empty or is being drained this cycle.
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_hi     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
    end else if (adv) begin
      s1_valid  <= in_valid;
      if (in_valid) begin
        s1_hi <= hi_c;
      end
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_data <= q_c;
        out_sat  <= sat_c;
      end
    end
  end

`ifdef SAT_COUNT_EN
  // Counts clamped samples as they leave the block; saturates at all-ones.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sat_count <= '0;
    end else if (sat_clr) begin
      sat_count <= '0;
    end else if (out_valid && out_ready && out_sat && !(&sat_count)) begin
      sat_count <= sat_count + CNT_W'(1);
    end
  end
`endif

endmodule
